// File: rtl/control_unit_pkg.sv
// Control-unit types: writeback source select and operand forwarding select.
package control_unit_pkg;

  typedef enum logic [1:0] {
    RS_ALU = 2'd0,
    RS_MEM = 2'd1,
    RS_PC  = 2'd2,
    RS_LUI = 2'd3
  } regsel_t;

  // FWD_RSVD is an unused encoding and selects the register file, like FWD_RF.
  typedef enum logic [1:0] {
    FWD_RF   = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2,
    FWD_RSVD = 2'd3
  } fwdsel_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word width, register index and ALU operation codes.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [4:0]        regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

endpackage

// File: rtl/execute_stage_pkg.sv
// Execute-stage local types: EX/MEM latch contents, latch action and forwarding mux.
package execute_stage_pkg;

  import cpu_types_pkg::*;
  import control_unit_pkg::*;

  typedef struct packed {
    word_t    npc;
    logic     dren;
    logic     dwen;
    logic     regwr;
    logic     halt;
    regsel_t  regsel;
    regbits_t regdst;
    word_t    aluout;
    word_t    rtdat;
  } exmem_t;

  typedef enum logic [1:0] {
    LATCH_HOLD   = 2'd0,
    LATCH_LOAD   = 2'd1,
    LATCH_BUBBLE = 2'd2
  } latch_act_t;

  // Operand source: EX/MEM result, writeback data, or the register file read.
  function automatic word_t fwd_mux(fwdsel_t sel, word_t rf, word_t mem, word_t wb);
    case (sel)
      FWD_MEM: return mem;
      FWD_WB:  return wb;
      default: return rf;
    endcase
  endfunction

endpackage

// File: rtl/execute_if.sv
// ID/EX-to-EX/MEM boundary signals of the execute stage.
interface execute_if;

  import cpu_types_pkg::*;
  import control_unit_pkg::*;

  // ID/EX side and hazard/memory status
  logic     ihit, dhit, flush;
  word_t    nPC, rsdat, rtdat, imm, wbdat;
  logic [4:0] shamt;
  aluop_t   aluop;
  logic     ALUSrc;
  logic     dREN, dWEN, regWr, halt, beq, bne, jr;
  regsel_t  regSel;
  regbits_t regDst;
  fwdsel_t  fwdA, fwdB;

  // EX/MEM latch outputs, redirect and ID/EX advance enable
  word_t    nPC_next, ALUOut_next, rtdat_next;
  logic     dREN_next, dWEN_next, regWr_next, halt_next;
  regsel_t  regSel_next;
  regbits_t regDst_next;
  logic     redirect;
  word_t    redirect_pc;
  logic     idex_en;

  modport ex (
    input  ihit, dhit, flush, nPC, rsdat, rtdat, imm, wbdat, shamt, aluop, ALUSrc,
           dREN, dWEN, regWr, halt, beq, bne, jr, regSel, regDst, fwdA, fwdB,
    output nPC_next, ALUOut_next, rtdat_next, dREN_next, dWEN_next, regWr_next,
           halt_next, regSel_next, regDst_next, redirect, redirect_pc, idex_en
  );

  modport pipe (
    output ihit, dhit, flush, nPC, rsdat, rtdat, imm, wbdat, shamt, aluop, ALUSrc,
           dREN, dWEN, regWr, halt, beq, bne, jr, regSel, regDst, fwdA, fwdB,
    input  nPC_next, ALUOut_next, rtdat_next, dREN_next, dWEN_next, regWr_next,
           halt_next, regSel_next, regDst_next, redirect, redirect_pc, idex_en
  );

endinterface

// File: rtl/alu.sv
// Combinational ALU: shifts act on op_b, add/sub wrap, signed/unsigned set-less-than.
module alu
  import cpu_types_pkg::*;
(
  input  word_t      op_a,
  input  word_t      op_b,
  input  logic [4:0] shamt,
  input  aluop_t     aluop,
  output word_t      result,
  output logic       zero,
  output logic       overflow
);

  // Operation select; overflow reports signed add/sub overflow only.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    result   = '0;
    overflow = 1'b0;
    case (aluop)
      ALU_SLL:  result = op_b << shamt;
      ALU_SRL:  result = op_b >> shamt;
      ALU_ADD: begin
        result   = op_a + op_b;
        overflow = (op_a[WORD_W-1] == op_b[WORD_W-1]) && (result[WORD_W-1] != op_a[WORD_W-1]);
      end
      ALU_SUB: begin
        result   = op_a - op_b;
        overflow = (op_a[WORD_W-1] != op_b[WORD_W-1]) && (result[WORD_W-1] != op_a[WORD_W-1]);
      end
      ALU_AND:  result = op_a & op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_XOR:  result = op_a ^ op_b;
      ALU_NOR:  result = ~(op_a | op_b);
      ALU_SLT:  result = {{(WORD_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: result = {{(WORD_W-1){1'b0}}, (op_a < op_b)};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: forwarding, ALU, branch/JR resolution and the EX/MEM latch.
module execute_stage
  import cpu_types_pkg::*;
  import control_unit_pkg::*;
  import execute_stage_pkg::*;
(
  input logic CLK,
  input logic nRST,
  execute_if.ex exif
);

  word_t      op_a, rt_f, op_b, alu_b, alu_result;
  logic       alu_zero_unused, alu_ovf_unused;
  logic       memwait;
  latch_act_t act;
  exmem_t     exmem_d, exmem_q;

  // Operand forwarding and B-operand select; shifts always take the forwarded rt.
  always_comb begin
    op_a  = fwd_mux(exif.fwdA, exif.rsdat, exmem_q.aluout, exif.wbdat);
    rt_f  = fwd_mux(exif.fwdB, exif.rtdat, exmem_q.aluout, exif.wbdat);
    op_b  = exif.ALUSrc ? exif.imm : rt_f;
    alu_b = ((exif.aluop == ALU_SLL) || (exif.aluop == ALU_SRL)) ? rt_f : op_b;
  end

  // The stage does not trap or use the zero flag; those ALU outputs are left unused.
  alu u_alu (
    .op_a     (op_a),
    .op_b     (alu_b),
    .shamt    (exif.shamt),
    .aluop    (exif.aluop),
    .result   (alu_result),
    .zero     (alu_zero_unused),
    .overflow (alu_ovf_unused)
  );

  // Same-cycle redirect: JR wins over a taken conditional branch.
  always_comb begin
    exif.redirect    = 1'b0;
    exif.redirect_pc = exif.nPC;
    if (exif.jr) begin
      exif.redirect    = 1'b1;
      exif.redirect_pc = op_a;
    end else if ((exif.beq && (op_a == rt_f)) || (exif.bne && (op_a != rt_f))) begin
      exif.redirect    = 1'b1;
      exif.redirect_pc = exif.nPC + (exif.imm << 2);
    end
  end

  // EX/MEM action: sticky halt, flush, then hold an outstanding memory access
  // until dhit; a completed access is never re-issued (bubble if no new fetch).
  always_comb begin
    memwait = exmem_q.dren | exmem_q.dwen;
    act     = LATCH_HOLD;
    if (exmem_q.halt) begin
      act = LATCH_HOLD;
    end else if (exif.flush && (exif.ihit || exif.dhit)) begin
      act = LATCH_BUBBLE;
    end else if (memwait) begin
      if (!exif.dhit)     act = LATCH_HOLD;
      else if (exif.ihit) act = LATCH_LOAD;
      else                act = LATCH_BUBBLE;
    end else if (exif.ihit) begin
      act = LATCH_LOAD;
    end
  end

  // ID/EX advances exactly when EX/MEM loads.
  assign exif.idex_en = nRST && (act == LATCH_LOAD);

  // Next EX/MEM contents from the chosen action.
  always_comb begin
    exmem_d = exmem_q;
    case (act)
      LATCH_LOAD: begin
        exmem_d.npc    = exif.nPC;
        exmem_d.dren   = exif.dREN;
        exmem_d.dwen   = exif.dWEN;
        exmem_d.regwr  = exif.regWr;
        exmem_d.halt   = exif.halt;
        exmem_d.regsel = exif.regSel;
        exmem_d.regdst = exif.regDst;
        exmem_d.aluout = alu_result;
        exmem_d.rtdat  = rt_f;
      end
      LATCH_BUBBLE: exmem_d = '0;
      default:      exmem_d = exmem_q;
    endcase
  end

  // EX/MEM register with synchronous active-low reset to a bubble.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignment so the latch samples values from before the edge.
    if (!nRST) exmem_q <= '0;
    else       exmem_q <= exmem_d;
  end

  assign exif.nPC_next    = exmem_q.npc;
  assign exif.ALUOut_next = exmem_q.aluout;
  assign exif.rtdat_next  = exmem_q.rtdat;
  assign exif.dREN_next   = exmem_q.dren;
  assign exif.dWEN_next   = exmem_q.dwen;
  assign exif.regWr_next  = exmem_q.regwr;
  assign exif.halt_next   = exmem_q.halt;
  assign exif.regSel_next = exmem_q.regsel;
  assign exif.regDst_next = exmem_q.regdst;

endmodule

// File: tb/tb_execute_stage.sv
// Randomized self-checking bench for execute_stage against a behavioural model.
module tb_execute_stage;

  import cpu_types_pkg::*;
  import control_unit_pkg::*;

  localparam int A_HOLD = 0;
  localparam int A_LOAD = 1;
  localparam int A_BUB  = 2;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  execute_if exif ();

  execute_stage dut (
    .CLK  (clk),
    .nRST (nrst),
    .exif (exif)
  );

  // Expected EX/MEM contents
  typedef struct {
    logic [31:0] npc, alu, rt;
    logic        dren, dwen, regwr, halt;
    logic [1:0]  regsel;
    logic [4:0]  regdst;
  } model_t;

  model_t m;
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd_pick(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'd1) return m.alu;
    if (sel == 2'd2) return exif.wbdat;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input aluop_t op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] rt,
                                         input logic [4:0] sh);
    case (op)
      ALU_SLL:  return rt << sh;
      ALU_SRL:  return rt >> sh;
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int next_action();
    logic busy;
    busy = m.dren | m.dwen;
    if (!nrst)                            return A_BUB;
    if (m.halt)                           return A_HOLD;
    if (exif.flush && (exif.ihit || exif.dhit)) return A_BUB;
    if (busy && !exif.dhit)               return A_HOLD;
    if (busy && exif.ihit)                return A_LOAD;
    if (busy)                             return A_BUB;
    if (exif.ihit)                        return A_LOAD;
    return A_HOLD;
  endfunction

  task automatic clear_inputs();
    exif.ihit = 0; exif.dhit = 0; exif.flush = 0;
    exif.nPC = 0; exif.rsdat = 0; exif.rtdat = 0; exif.imm = 0; exif.wbdat = 0;
    exif.shamt = 0; exif.aluop = ALU_ADD; exif.ALUSrc = 0;
    exif.dREN = 0; exif.dWEN = 0; exif.regWr = 0; exif.halt = 0;
    exif.beq = 0; exif.bne = 0; exif.jr = 0;
    exif.regSel = RS_ALU; exif.regDst = 0; exif.fwdA = FWD_RF; exif.fwdB = FWD_RF;
  endtask

  task automatic rand_inputs();
    exif.ihit   = ($urandom_range(0, 99) < 75);
    exif.dhit   = ($urandom_range(0, 99) < 50);
    exif.flush  = ($urandom_range(0, 99) < 15);
    exif.nPC    = $urandom;
    exif.rtdat  = $urandom;
    exif.rsdat  = ($urandom_range(0, 99) < 30) ? exif.rtdat : $urandom;
    exif.imm    = $urandom;
    exif.wbdat  = $urandom;
    exif.shamt  = 5'($urandom_range(0, 31));
    exif.aluop  = aluop_t'(4'($urandom_range(0, 9)));
    exif.ALUSrc = 1'($urandom_range(0, 1));
    exif.dREN   = ($urandom_range(0, 99) < 30);
    exif.dWEN   = ($urandom_range(0, 99) < 20);
    exif.regWr  = 1'($urandom_range(0, 1));
    exif.halt   = 0;
    exif.beq    = ($urandom_range(0, 99) < 20);
    exif.bne    = ($urandom_range(0, 99) < 20);
    exif.jr     = ($urandom_range(0, 99) < 20);
    exif.regSel = regsel_t'(2'($urandom_range(0, 3)));
    exif.regDst = 5'($urandom_range(0, 31));
    exif.fwdA   = fwdsel_t'(2'($urandom_range(0, 3)));
    exif.fwdB   = fwdsel_t'(2'($urandom_range(0, 3)));
  endtask

  // Combinational outputs, checked shortly after inputs change (mid-cycle)
  task automatic settle();
    logic [31:0] a, rt, tgt;
    logic        taken;
    #1;
    a     = fwd_pick(exif.fwdA, exif.rsdat);
    rt    = fwd_pick(exif.fwdB, exif.rtdat);
    taken = 1'b0;
    tgt   = exif.nPC;
    if (exif.jr) begin
      taken = 1'b1;
      tgt   = a;
    end else if ((exif.beq && a == rt) || (exif.bne && a != rt)) begin
      taken = 1'b1;
      tgt   = exif.nPC + exif.imm * 32'd4;
    end
    check("redirect", exif.redirect, taken);
    check("redirect_pc", exif.redirect_pc, tgt);
    check("idex_en", exif.idex_en, next_action() == A_LOAD);
  endtask

  // Clock edge: advance the model, then check the latch outputs after the edge
  task automatic clock();
    int act;
    logic [31:0] a, rt, b, res;
    act = next_action();
    a   = fwd_pick(exif.fwdA, exif.rsdat);
    rt  = fwd_pick(exif.fwdB, exif.rtdat);
    b   = exif.ALUSrc ? exif.imm : rt;
    res = ref_alu(exif.aluop, a, b, rt, exif.shamt);
    @(posedge clk);
    if (act == A_BUB) begin
      m = '{default: '0};
    end else if (act == A_LOAD) begin
      m.npc = exif.nPC; m.alu = res; m.rt = rt;
      m.dren = exif.dREN; m.dwen = exif.dWEN; m.regwr = exif.regWr; m.halt = exif.halt;
      m.regsel = exif.regSel; m.regdst = exif.regDst;
    end
    #1;
    check("nPC_next", exif.nPC_next, m.npc);
    check("ALUOut_next", exif.ALUOut_next, m.alu);
    check("rtdat_next", exif.rtdat_next, m.rt);
    check("dREN_next", exif.dREN_next, m.dren);
    check("dWEN_next", exif.dWEN_next, m.dwen);
    check("regWr_next", exif.regWr_next, m.regwr);
    check("halt_next", exif.halt_next, m.halt);
    check("regSel_next", exif.regSel_next, m.regsel);
    check("regDst_next", exif.regDst_next, m.regdst);
  endtask

  task automatic step();
    settle();
    clock();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int pick;
    m = '{default: '0};
    nrst = 1'b0;
    clear_inputs();

    // Reset: random inputs, fetch active; forwarding from the unknown latch avoided
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rand_inputs();
      exif.ihit = 1;
      pick = $urandom_range(0, 2);
      exif.fwdA = (pick == 0) ? FWD_RF : (pick == 1) ? FWD_WB : FWD_RSVD;
      pick = $urandom_range(0, 2);
      exif.fwdB = (pick == 0) ? FWD_RF : (pick == 1) ? FWD_WB : FWD_RSVD;
      nrst = 1'b0;
      step();
      check("rst_alu", exif.ALUOut_next, 32'h0);
    end
    nrst = 1'b1;

    // Forwarding
    @(negedge clk); clear_inputs();
    exif.rsdat = 32'h8; exif.rtdat = 32'h8; exif.ihit = 1;
    step();
    check("fwd_seed", exif.ALUOut_next, 32'h10);
    @(negedge clk); clear_inputs();
    exif.fwdA = FWD_MEM; exif.rsdat = 32'h99; exif.fwdB = FWD_WB; exif.wbdat = 32'h5;
    exif.rtdat = 32'h77; exif.ihit = 1;
    step();
    check("fwd_alu", exif.ALUOut_next, 32'h15);
    check("fwd_rt", exif.rtdat_next, 32'h5);

    // Load stall then completion without a new fetch
    @(negedge clk); clear_inputs();
    exif.rsdat = 32'h1000; exif.imm = 32'h4; exif.ALUSrc = 1; exif.dREN = 1;
    exif.regWr = 1; exif.regSel = RS_MEM; exif.regDst = 5'd5; exif.ihit = 1;
    step();
    check("lw_dren", exif.dREN_next, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); rand_inputs();
      exif.ihit = 1; exif.dhit = 0; exif.flush = 0;
      step();
      check("stall_dren", exif.dREN_next, 1'b1);
      check("stall_alu", exif.ALUOut_next, 32'h1004);
    end
    @(negedge clk); rand_inputs();
    exif.ihit = 0; exif.dhit = 1; exif.flush = 0;
    step();
    check("done_dren", exif.dREN_next, 1'b0);
    check("done_regwr", exif.regWr_next, 1'b0);

    // Branch resolution
    @(negedge clk); clear_inputs();
    exif.beq = 1; exif.rsdat = 32'h7; exif.rtdat = 32'h7; exif.nPC = 32'h100; exif.imm = 32'h3;
    settle();
    check("beq_taken", exif.redirect, 1'b1);
    check("beq_target", exif.redirect_pc, 32'h10C);
    exif.rtdat = 32'h8;
    settle();
    check("beq_not_taken", exif.redirect, 1'b0);
    check("beq_fallthru", exif.redirect_pc, 32'h100);
    clock();

    // Flush: hold without a hit, bubble with one
    @(negedge clk); clear_inputs();
    exif.rsdat = 32'h1; exif.rtdat = 32'h2; exif.regWr = 1; exif.regDst = 5'd3; exif.ihit = 1;
    step();
    @(negedge clk); clear_inputs();
    exif.flush = 1; exif.dWEN = 1;
    step();
    check("flush_hold_regwr", exif.regWr_next, 1'b1);
    check("flush_hold_alu", exif.ALUOut_next, 32'h3);
    @(negedge clk); clear_inputs();
    exif.flush = 1; exif.ihit = 1; exif.dWEN = 1;
    step();
    check("flush_dwen", exif.dWEN_next, 1'b0);

    // Signed vs unsigned compare
    @(negedge clk); clear_inputs();
    exif.aluop = ALU_SLT; exif.rsdat = 32'hFFFF_FFFF; exif.rtdat = 32'h1; exif.ihit = 1;
    step();
    check("slt", exif.ALUOut_next, 32'h1);
    @(negedge clk);
    exif.aluop = ALU_SLTU;
    step();
    check("sltu", exif.ALUOut_next, 32'h0);

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); rand_inputs();
      nrst = ($urandom_range(0, 99) >= 3);
      step();
    end
    nrst = 1'b1;

    // Halt is sticky until reset
    @(negedge clk); clear_inputs(); nrst = 1'b0;
    step();
    nrst = 1'b1;
    @(negedge clk); clear_inputs();
    exif.halt = 1; exif.rsdat = 32'h21; exif.rtdat = 32'h21; exif.regWr = 1; exif.ihit = 1;
    step();
    check("halt_set", exif.halt_next, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); rand_inputs();
      exif.ihit = 1;
      step();
      check("halt_sticky", exif.halt_next, 1'b1);
      check("halt_frozen", exif.ALUOut_next, 32'h42);
    end
    @(negedge clk); clear_inputs(); exif.ihit = 1; nrst = 1'b0;
    step();
    check("halt_cleared", exif.halt_next, 1'b0);
    nrst = 1'b1;
    @(negedge clk); clear_inputs();
    exif.rsdat = 32'h3; exif.rtdat = 32'h4; exif.ihit = 1;
    step();
    check("after_halt_load", exif.ALUOut_next, 32'h7);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 5-stage pipeline, directly upstream of the memory stage.
- Takes decoded operands and controls from the ID/EX latch and applies operand forwarding, the ALU, and branch/JR resolution.
- Registers the result into the EX/MEM latch, whose outputs are the memory stage's inputs: nPC, dREN, dWEN, regWr, regSel, regDst, ALUOut, rtdat.
- Owns the EX/MEM stall, flush and bubble rules.

Parameters:
- WORD_W, 32, datapath width; equals word_t, fixed.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  synchronous active-low reset
- ihit  in  1  instruction fetch completed this cycle
- dhit  in  1  data access of the memory stage completed this cycle
- flush  in  1  hazard unit: squash the instruction entering EX/MEM
- nPC  in  32  PC+4 of the instruction in EX
- rsdat, rtdat  in  32 each  register-file read data
- imm  in  32  extended immediate
- shamt  in  5  shift amount
- aluop  in  4  aluop_t
- ALUSrc  in  1  1 = B operand is imm
- dREN, dWEN, regWr, halt, beq, bne, jr  in  1 each  decoded controls
- regSel  in  2  regsel_t
- regDst  in  5  regbits_t
- fwdA, fwdB  in  2  fwdsel_t: 0 = register file, 1 = EX/MEM ALUOut_next, 2 = wbdat
- wbdat  in  32  writeback data
- nPC_next, ALUOut_next, rtdat_next  out  32 each  EX/MEM registered
- dREN_next, dWEN_next, regWr_next, halt_next  out  1 each  EX/MEM registered
- regSel_next  out  2  EX/MEM registered
- regDst_next  out  5  EX/MEM registered
- redirect  out  1  combinational: taken branch or JR
- redirect_pc  out  32  combinational target

Behaviour:
- Reset (nRST low at posedge): all *_next outputs are 0, i.e. a bubble. Reset mid-stall discards the held instruction.
- Forwarding:
  - opA = mux(fwdA) of rsdat, ALUOut_next, wbdat.
  - rtF = mux(fwdB) of rtdat, ALUOut_next, wbdat.
  - fwdsel 3 behaves as 0.
- opB = ALUSrc ? imm : rtF.
- ALU (aluop):
  - SLL/SRL: rtF shifted by shamt.
  - ADD/SUB: wrap modulo 2^32; no trap.
  - AND, OR, XOR, NOR.
  - SLT: signed. SLTU: unsigned. Result 1 or 0.
- Redirect:
  - beq & (opA==rtF), or bne & (opA!=rtF): redirect=1, redirect_pc = nPC + (imm<<2).
  - jr: redirect=1, redirect_pc = opA. jr takes priority if asserted with beq/bne.
  - Otherwise redirect=0, redirect_pc = nPC.
- Latch "load" captures: nPC; ALU result; rtF into rtdat_next; all controls.
- Latch "bubble" clears dREN, dWEN, regWr, halt and regSel; datapath fields are don't-care (driven 0).
- memwait = dREN_next | dWEN_next. Priority per posedge:
  1. nRST low -> bubble.
  2. halt_next == 1 -> hold. Halt is sticky until reset.
  3. flush & (ihit | dhit) -> bubble.
  4. memwait & ~dhit -> hold. The memory request stays stable; ihit is ignored.
  5. memwait & dhit & ihit -> load.
  6. memwait & dhit & ~ihit -> bubble. This prevents re-issuing a completed access.
  7. ~memwait & ihit -> load.
  8. otherwise -> hold.
- Latency: one cycle from ID/EX inputs to *_next outputs. redirect is same-cycle combinational.
- The ID/EX latch advances with the same load condition; this enable is exported in the execute_if interface.

Decomposition:
- cpu_types_pkg: aluop_t encodings, word_t, regbits_t.
- control_unit_pkg: regsel_t, and new fwdsel_t (FWD_RF, FWD_MEM, FWD_WB).
- New interface execute_if with modport ex carrying the ports above.
- One sub-module: alu (combinational, opA/opB/shamt/aluop -> result, zero, overflow), instantiated once.
- Latch rules and forwarding/redirect logic stay in execute_stage.

Test Plan:
- Reset: nRST=0 for 2 cycles with random inputs and ihit=1 -> every *_next = 0; redirect follows inputs only.
- Forward: ADD with fwdA=1, ALUOut_next=0x10, rsdat=0x99, fwdB=2, wbdat=0x5, ALUSrc=0, ihit=1 -> next ALUOut_next=0x15, rtdat_next=0x5.
- Load stall: latch holds a lw (dREN_next=1); drive ihit=1 and dhit=0 for 3 cycles, then dhit=1, ihit=0 -> outputs unchanged for 3 cycles, then bubble (dREN_next=0, regWr_next=0).
- Branch: beq, opA=rtF=7, nPC=0x100, imm=0x3 -> redirect=1, redirect_pc=0x10C. Change rtF to 8 -> redirect=0, redirect_pc=0x100.
- Flush: flush=1, ihit=1, incoming sw -> dWEN_next=0. Flush=1 with ihit=0, dhit=0 -> hold.
- Halt and SLT: halt=1 latched, then 5 ihit cycles with new inputs -> halt_next stays 1, outputs frozen. SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0.
